// File: rtl/snow64_scalar_data_access_scheduler_pkg.sv
// rtl/snow64_scalar_data_access_scheduler_pkg.sv - shared types for the scalar data access scheduler
package snow64_scalar_data_access_scheduler_pkg;

  localparam int LAR_DATA_WIDTH    = 256;
  localparam int SCALAR_DATA_WIDTH = 64;
  localparam int DATA_OFFSET_WIDTH = 5;

  typedef logic [LAR_DATA_WIDTH-1:0]    lar_data_t;
  typedef logic [SCALAR_DATA_WIDTH-1:0] scalar_data_t;
  typedef logic [DATA_OFFSET_WIDTH-1:0] data_offset_t;

  typedef enum logic [1:0] {
    DT_UNSGN_INT,
    DT_SGN_INT,
    DT_BFLOAT16,
    DT_RESERVED
  } cpu_data_type_t;

  typedef enum logic [1:0] {
    INT_SIZE_8,
    INT_SIZE_16,
    INT_SIZE_32,
    INT_SIZE_64
  } int_type_size_t;

  typedef enum logic [1:0] {
    OP_EXTRACT,
    OP_INJECT,
    OP_SWAP,
    OP_RESERVED
  } scalar_access_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } sched_state_t;

  typedef struct packed {
    scalar_access_op_t op;
    lar_data_t         lar_data;
    scalar_data_t      scalar_data;
    cpu_data_type_t    data_type;
    int_type_size_t    int_type_size;
    data_offset_t      data_offset;
  } port_in_scalar_access_req_t;

  typedef struct packed {
    logic         requester_id;
    scalar_data_t scalar;
    lar_data_t    lar;
    logic         err;
  } port_out_scalar_access_resp_t;

  // bfloat16 scalars always occupy 16 bits regardless of the int size field
  function automatic int_type_size_t effective_size(cpu_data_type_t dt, int_type_size_t sz);
    int_type_size_t res;
    res = (dt == DT_BFLOAT16) ? INT_SIZE_16 : sz;
    return res;
  endfunction

  function automatic scalar_data_t size_mask(int_type_size_t sz);
    scalar_data_t m;
    case (sz)
      INT_SIZE_8:  m = 64'h0000_0000_0000_00ff;
      INT_SIZE_16: m = 64'h0000_0000_0000_ffff;
      INT_SIZE_32: m = 64'h0000_0000_ffff_ffff;
      default:     m = 64'hffff_ffff_ffff_ffff;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/snow64_scalar_data_access_scheduler_if.sv
// rtl/snow64_scalar_data_access_scheduler_if.sv - requester/response bundle for the scheduler
interface snow64_scalar_data_access_scheduler_if;
  import snow64_scalar_data_access_scheduler_pkg::*;

  logic [1:0]                       req_valid;
  logic [1:0]                       req_ready;
  port_in_scalar_access_req_t [1:0] req;
  logic                             resp_valid;
  logic                             resp_ready;
  port_out_scalar_access_resp_t     resp;

  modport master (
    output req_valid, req, resp_ready,
    input  req_ready, resp_valid, resp
  );

  modport slave (
    input  req_valid, req, resp_ready,
    output req_ready, resp_valid, resp
  );

endinterface

// File: rtl/snow64_round_robin_arb2.sv
// rtl/snow64_round_robin_arb2.sv - two-way round-robin arbiter holding the last grant
module snow64_round_robin_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       update,
  output logic       grant
);

  logic last_grant;

  // Contention (or no request) favours the requester that did not win last time
  always_comb begin
    grant = ~last_grant;
    if (valid == 2'b01) begin
      grant = 1'b0;
    end else if (valid == 2'b10) begin
      grant = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= grant;
    end
  end

endmodule

// File: rtl/snow64_scalar_data_extractor.sv
// rtl/snow64_scalar_data_extractor.sv - pulls one scalar out of a LAR line at a byte offset
module snow64_scalar_data_extractor
  import snow64_scalar_data_access_scheduler_pkg::*;
(
  input  lar_data_t      lar_data,
  input  cpu_data_type_t data_type,
  input  int_type_size_t int_type_size,
  input  data_offset_t   data_offset,
  output scalar_data_t   scalar_data
);

  int_type_size_t size;
  scalar_data_t   raw;
  logic [7:0]     shamt;

  assign size  = effective_size(data_type, int_type_size);
  assign shamt = {data_offset, 3'b000};
  assign raw   = 64'(lar_data >> shamt);

  always_comb begin
    scalar_data = raw & size_mask(size);
    if (data_type == DT_SGN_INT) begin
      case (size)
        INT_SIZE_8:  scalar_data = {{56{raw[7]}}, raw[7:0]};
        INT_SIZE_16: scalar_data = {{48{raw[15]}}, raw[15:0]};
        INT_SIZE_32: scalar_data = {{32{raw[31]}}, raw[31:0]};
        default:     scalar_data = raw;
      endcase
    end
  end

endmodule

// File: rtl/snow64_scalar_data_injector.sv
// rtl/snow64_scalar_data_injector.sv - writes one scalar into a LAR line at a byte offset
module snow64_scalar_data_injector
  import snow64_scalar_data_access_scheduler_pkg::*;
(
  input  lar_data_t      lar_data,
  input  scalar_data_t   scalar_data,
  input  cpu_data_type_t data_type,
  input  int_type_size_t int_type_size,
  input  data_offset_t   data_offset,
  output lar_data_t      lar_out
);

  scalar_data_t mask;
  logic [7:0]   shamt;
  lar_data_t    field_mask;
  lar_data_t    field;

  assign mask       = size_mask(effective_size(data_type, int_type_size));
  assign shamt      = {data_offset, 3'b000};
  assign field_mask = lar_data_t'(mask) << shamt;
  assign field      = lar_data_t'(scalar_data & mask) << shamt;
  assign lar_out    = (lar_data & ~field_mask) | field;

endmodule

// File: rtl/snow64_scalar_data_access_scheduler.sv
// rtl/snow64_scalar_data_access_scheduler.sv - arbitrates two requesters onto one extractor/injector pair
module snow64_scalar_data_access_scheduler
  import snow64_scalar_data_access_scheduler_pkg::*;
(
  input logic clk,
  input logic rst,
  snow64_scalar_data_access_scheduler_if.slave bus
);

  sched_state_t                 state;
  port_in_scalar_access_req_t   operand;
  logic                         operand_id;
  logic                         grant;
  logic                         accept_window;
  logic                         accept;
  scalar_data_t                 extracted;
  lar_data_t                    injected;
  port_out_scalar_access_resp_t exec_resp;

  snow64_round_robin_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (bus.req_valid),
    .update (accept),
    .grant  (grant)
  );

  // A new request may enter while the current response is being consumed
  assign accept_window = (state == ST_IDLE) || ((state == ST_RESP) && bus.resp_ready);
  assign bus.req_ready = {!rst && grant && accept_window, !rst && !grant && accept_window};
  assign accept        = |(bus.req_valid & bus.req_ready);

  snow64_scalar_data_extractor u_extractor (
    .lar_data      (operand.lar_data),
    .data_type     (operand.data_type),
    .int_type_size (operand.int_type_size),
    .data_offset   (operand.data_offset),
    .scalar_data   (extracted)
  );

  snow64_scalar_data_injector u_injector (
    .lar_data      (operand.lar_data),
    .scalar_data   (operand.scalar_data),
    .data_type     (operand.data_type),
    .int_type_size (operand.int_type_size),
    .data_offset   (operand.data_offset),
    .lar_out       (injected)
  );

  always_comb begin
    exec_resp              = '0;
    exec_resp.requester_id = operand_id;
    exec_resp.lar          = operand.lar_data;
    case (operand.op)
      OP_EXTRACT: exec_resp.scalar = extracted;
      OP_INJECT: begin
        exec_resp.lar    = injected;
        exec_resp.scalar = operand.scalar_data;
      end
      OP_SWAP: begin
        exec_resp.scalar = extracted;
        exec_resp.lar    = injected;
      end
      default: exec_resp.err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      operand        <= '0;
      operand_id     <= 1'b0;
      bus.resp       <= '0;
      bus.resp_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            operand    <= bus.req[grant];
            operand_id <= grant;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.resp       <= exec_resp;
          bus.resp_valid <= 1'b1;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            bus.resp_valid <= 1'b0;
            if (accept) begin
              operand    <= bus.req[grant];
              operand_id <= grant;
              state      <= ST_EXEC;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snow64_scalar_data_access_scheduler.sv
// tb/tb_snow64_scalar_data_access_scheduler.sv - directed bench for the scalar data access scheduler
module tb_snow64_scalar_data_access_scheduler;
  import snow64_scalar_data_access_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  snow64_scalar_data_access_scheduler_if bus_if();

  snow64_scalar_data_access_scheduler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  lar_data_t                    lar_inc;
  lar_data_t                    lar_exp;
  port_out_scalar_access_resp_t resp_exp;
  int                           n_acc;
  int                           got_id [4];
  int                           got_cyc[4];

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic port_in_scalar_access_req_t mk(input scalar_access_op_t op, input lar_data_t lar,
      input scalar_data_t sc, input cpu_data_type_t dt, input int_type_size_t sz, input data_offset_t off);
    port_in_scalar_access_req_t r;
    r.op = op; r.lar_data = lar; r.scalar_data = sc;
    r.data_type = dt; r.int_type_size = sz; r.data_offset = off;
    return r;
  endfunction

  // Issues one request alone and leaves the bench one step after the response appears
  task automatic single(input logic id, input port_in_scalar_access_req_t r);
    bus_if.req[id]       = r;
    bus_if.req_valid     = 2'b00;
    bus_if.req_valid[id] = 1'b1;
    bus_if.resp_ready    = 1'b0;
    #1;
    check("accept_ready", bus_if.req_ready, id ? 2'b10 : 2'b01);
    @(posedge clk); #1;
    bus_if.req_valid = 2'b00;
    check("exec_state", dut.state, ST_EXEC);
    check("exec_no_resp", bus_if.resp_valid, 1'b0);
    @(posedge clk); #1;
    check("resp_valid", bus_if.resp_valid, 1'b1);
  endtask

  task automatic consume;
    bus_if.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_if.resp_ready = 1'b0;
    check("consumed", bus_if.resp_valid, 1'b0);
    check("back_idle", dut.state, ST_IDLE);
  endtask

  initial begin
    for (int k = 0; k < 32; k++) lar_inc[k*8 +: 8] = 8'(k);
    bus_if.req        = '0;
    bus_if.req_valid  = 2'b11;
    bus_if.resp_ready = 1'b0;

    // Reset holds req_ready low even with both requesters valid
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus_if.req_ready, 2'b00);
    check("rst_resp_valid", bus_if.resp_valid, 1'b0);
    check("rst_resp", bus_if.resp, '0);
    check("rst_state", dut.state, ST_IDLE);
    bus_if.req_valid = 2'b00;
    rst = 1'b0;
    @(posedge clk); #1;

    single(1'b0, mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_32, 5'd4));
    check("ext_id", bus_if.resp.requester_id, 1'b0);
    check("ext_scalar", bus_if.resp.scalar, 64'h0706_0504);
    check("ext_lar", bus_if.resp.lar, lar_inc);
    check("ext_err", bus_if.resp.err, 1'b0);
    consume();

    single(1'b1, mk(OP_INJECT, '0, 64'hAB, DT_UNSGN_INT, INT_SIZE_8, 5'd31));
    check("inj_id", bus_if.resp.requester_id, 1'b1);
    check("inj_lar", bus_if.resp.lar, {8'hAB, 248'h0});
    check("inj_scalar", bus_if.resp.scalar, 64'hAB);
    consume();

    lar_exp = lar_inc;
    lar_exp[23:16] = 8'hEF;
    lar_exp[31:24] = 8'hBE;
    single(1'b0, mk(OP_SWAP, lar_inc, 64'hBEEF, DT_UNSGN_INT, INT_SIZE_16, 5'd2));
    check("swap_scalar", bus_if.resp.scalar, 64'h0302);
    check("swap_lar", bus_if.resp.lar, lar_exp);
    check("swap_err", bus_if.resp.err, 1'b0);
    consume();

    single(1'b1, mk(OP_EXTRACT, '1, 64'h0, DT_SGN_INT, INT_SIZE_8, 5'd0));
    check("sext_scalar", bus_if.resp.scalar, 64'hFFFF_FFFF_FFFF_FFFF);
    consume();

    single(1'b0, mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_64, 5'd24));
    check("ext64_scalar", bus_if.resp.scalar, 64'h1F1E_1D1C_1B1A_1918);
    consume();

    single(1'b1, mk(OP_RESERVED, lar_inc, 64'h55, DT_UNSGN_INT, INT_SIZE_32, 5'd0));
    check("rsv_err", bus_if.resp.err, 1'b1);
    check("rsv_scalar", bus_if.resp.scalar, 64'h0);
    check("rsv_lar", bus_if.resp.lar, lar_inc);
    consume();

    // Round robin from a fresh reset: requester 0 wins first, then strict alternation
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus_if.req[0]     = mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_8, 5'd0);
    bus_if.req[1]     = mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_8, 5'd1);
    bus_if.req_valid  = 2'b11;
    bus_if.resp_ready = 1'b1;
    n_acc = 0;
    for (int cyc = 0; cyc < 20 && n_acc < 4; cyc++) begin
      #1;
      check("rr_not_both", &bus_if.req_ready, 1'b0);
      if (bus_if.req_ready[0] || bus_if.req_ready[1]) begin
        got_id[n_acc]  = bus_if.req_ready[1] ? 1 : 0;
        got_cyc[n_acc] = cyc;
        n_acc++;
      end
      @(posedge clk); #1;
    end
    bus_if.req_valid = 2'b00;
    check("rr_count", n_acc, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_grant", got_id[i], i % 2);
      if (i > 0) check("rr_spacing", got_cyc[i] - got_cyc[i-1], 2);
    end
    @(posedge clk); #1;
    check("rr_last_id", bus_if.resp.requester_id, 1'b1);
    check("rr_last_scalar", bus_if.resp.scalar, 64'h1);
    @(posedge clk); #1;
    bus_if.resp_ready = 1'b0;
    check("rr_idle", dut.state, ST_IDLE);

    // Back-pressure: response frozen, nothing accepted, then hand-over in the same cycle
    single(1'b0, mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_8, 5'd5));
    resp_exp = '{requester_id: 1'b0, scalar: 64'h5, lar: lar_inc, err: 1'b0};
    bus_if.req[1]    = mk(OP_INJECT, '0, 64'h1234, DT_UNSGN_INT, INT_SIZE_16, 5'd0);
    bus_if.req_valid = 2'b10;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("stall_valid", bus_if.resp_valid, 1'b1);
      check("stall_resp", bus_if.resp, resp_exp);
      check("stall_ready", bus_if.req_ready, 2'b00);
      @(posedge clk); #1;
    end
    bus_if.resp_ready = 1'b1;
    #1;
    check("handover_ready", bus_if.req_ready, 2'b10);
    @(posedge clk); #1;
    bus_if.req_valid  = 2'b00;
    bus_if.resp_ready = 1'b0;
    check("handover_exec", dut.state, ST_EXEC);
    check("handover_drop_valid", bus_if.resp_valid, 1'b0);
    @(posedge clk); #1;
    check("handover_resp_valid", bus_if.resp_valid, 1'b1);
    check("handover_id", bus_if.resp.requester_id, 1'b1);
    check("handover_lar", bus_if.resp.lar, 256'h1234);
    check("handover_scalar", bus_if.resp.scalar, 64'h1234);
    consume();

    // Reset in EXEC drops the access
    bus_if.req[0]    = mk(OP_EXTRACT, lar_inc, 64'h0, DT_UNSGN_INT, INT_SIZE_8, 5'd3);
    bus_if.req_valid = 2'b01;
    @(posedge clk); #1;
    bus_if.req_valid = 2'b00;
    check("rst_exec_state", dut.state, ST_EXEC);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_exec_no_resp", bus_if.resp_valid, 1'b0);
    check("rst_exec_idle", dut.state, ST_IDLE);
    @(posedge clk); #1;
    check("rst_exec_still_none", bus_if.resp_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
